// File: rtl/load_size_unit.sv
// Load size-control: issues one word-aligned read per aligned request, then extracts and extends the loaded field.
// Latency: done/out in cycle 2+MEM_LATENCY after start (misaligned: done in cycle 1); start ignored while busy.
module load_size_unit #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic [31:0] out,
    output logic        busy,
    output logic        done,
    output logic        misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [1:0]  addr_lo_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic        mis_req;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;

    // Upper address bits live on in mem_addr; only the lane select needs latching.
    always_comb begin
        mis_req = 1'b0;
        case (size)
            2'b00:   mis_req = 1'b1;
            2'b10:   mis_req = addr[0];
            2'b11:   mis_req = (addr[1:0] != 2'b00);
            default: mis_req = 1'b0;
        endcase
    end

    always_comb begin
        byte_sel = 8'h00;
        case (addr_lo_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b01:   ext_data = {{24{sign_q & byte_sel[7]}}, byte_sel};
            2'b10:   ext_data = {{16{sign_q & half_sel[15]}}, half_sel};
            default: ext_data = mem_rdata;
        endcase
    end

    assign busy = (state == REQ) || (state == WAIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr_lo_q  <= 2'b00;
            size_q     <= 2'b00;
            sign_q     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_read   <= 1'b0;
            out        <= 32'h0;
            done       <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            mem_read <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        addr_lo_q <= addr[1:0];
                        size_q    <= size;
                        sign_q    <= sign_ext;
                        if (mis_req) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                        end else begin
                            state    <= REQ;
                            mem_read <= 1'b1;
                            mem_addr <= {addr[31:2], 2'b00};
                            cnt      <= 4'(MEM_LATENCY);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    state <= WAIT;
                    cnt   <= cnt - 4'd1;
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        out        <= ext_data;
                        state      <= DONE;
                        done       <= 1'b1;
                        misaligned <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_size_unit.sv
// Directed bench: table of single loads on a latency-1 unit, plus hand sequences on a latency-3 unit.
module tb_load_size_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start1 = 1'b0, start3 = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    logic [31:0] mem_addr1, out1, mem_addr3, out3;
    logic        mem_read1, busy1, done1, mis1;
    logic        mem_read3, busy3, done3, mis3;

    int ncmp = 0;
    int nfail = 0;

    always #5 clock = ~clock;

    load_size_unit #(.MEM_LATENCY(1)) u_dut1 (
        .clock(clock), .reset(reset), .start(start1), .addr(addr), .size(size),
        .sign_ext(sign_ext), .mem_rdata(mem_rdata), .mem_addr(mem_addr1),
        .mem_read(mem_read1), .out(out1), .busy(busy1), .done(done1), .misaligned(mis1));

    load_size_unit #(.MEM_LATENCY(3)) u_dut3 (
        .clock(clock), .reset(reset), .start(start3), .addr(addr), .size(size),
        .sign_ext(sign_ext), .mem_rdata(mem_rdata), .mem_addr(mem_addr3),
        .mem_read(mem_read3), .out(out3), .busy(busy3), .done(done3), .misaligned(mis3));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] rd;
        logic        mis;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[12];
    logic [31:0] last_out;

    task automatic run_vec(input vec_t v, input int idx);
        int cyc, reads;
        bit got;
        string tag;
        tag = $sformatf("v%0d", idx);
        addr = v.a; size = v.sz; sign_ext = v.sx; mem_rdata = v.rd; start1 = 1'b1;
        cyc = 0; reads = 0; got = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(posedge clock); #1;
            start1 = 1'b0;
            if (mem_read1) begin
                reads++;
                check({tag, " mem_addr"}, mem_addr1, {v.a[31:2], 2'b00});
                check({tag, " read cycle"}, i, 1);
            end
            if (done1) begin
                got = 1'b1;
                cyc = i;
            end
        end
        check({tag, " done latency"}, cyc, v.mis ? 1 : 3);
        check({tag, " mem_read count"}, reads, v.mis ? 0 : 1);
        check({tag, " misaligned"}, {31'h0, mis1}, {31'h0, v.mis});
        if (!v.mis) last_out = v.exp_out;
        check({tag, " out"}, out1, last_out);
    endtask

    initial begin
        int reads, dones, first_done, second_read;

        vecs[0]  = '{32'h100, 2'b01, 1'b1, 32'hCAFE8A7F, 1'b0, 32'h0000007F};
        vecs[1]  = '{32'h101, 2'b01, 1'b1, 32'hCAFE8A7F, 1'b0, 32'hFFFFFF8A};
        vecs[2]  = '{32'h101, 2'b01, 1'b0, 32'hCAFE8A7F, 1'b0, 32'h0000008A};
        vecs[3]  = '{32'h102, 2'b10, 1'b1, 32'hCAFE8A7F, 1'b0, 32'hFFFFCAFE};
        vecs[4]  = '{32'h104, 2'b11, 1'b1, 32'h12345678, 1'b0, 32'h12345678};
        vecs[5]  = '{32'h103, 2'b10, 1'b1, 32'hCAFE8A7F, 1'b1, 32'h0};
        vecs[6]  = '{32'h100, 2'b00, 1'b0, 32'hCAFE8A7F, 1'b1, 32'h0};
        vecs[7]  = '{32'h203, 2'b01, 1'b1, 32'hCAFE8A7F, 1'b0, 32'hFFFFFFCA};
        vecs[8]  = '{32'h200, 2'b10, 1'b0, 32'hCAFE8A7F, 1'b0, 32'h00008A7F};
        vecs[9]  = '{32'h302, 2'b11, 1'b0, 32'hCAFE8A7F, 1'b1, 32'h0};
        vecs[10] = '{32'h300, 2'b10, 1'b1, 32'hCAFE8A7F, 1'b0, 32'hFFFF8A7F};
        vecs[11] = '{32'h302, 2'b01, 1'b0, 32'hCAFE8A7F, 1'b0, 32'h000000FE};
        last_out = 32'h0;

        // Reset state while reset is held low
        #1;
        check("rst out", out1, 32'h0);
        check("rst mem_addr", mem_addr1, 32'h0);
        check("rst ctrl", {28'h0, mem_read1, busy1, done1, mis1}, 32'h0);
        @(posedge clock); @(posedge clock); #3;
        reset = 1'b1;
        @(posedge clock); #1;

        foreach (vecs[k]) run_vec(vecs[k], k);

        @(posedge clock); #1;
        check("idle done", {31'h0, done1}, 32'h0);
        check("idle busy", {31'h0, busy1}, 32'h0);
        check("out hold", out1, 32'h000000FE);

        // Latency 3: start during WAIT ignored, start in DONE accepted back-to-back
        addr = 32'h43; size = 2'b01; sign_ext = 1'b1; mem_rdata = 32'h80112233;
        reads = 0; dones = 0; first_done = 0; second_read = 0;
        for (int c = 0; c < 15; c++) begin
            start3 = (c == 0) || (c == 3) || (c == 5);
            @(posedge clock); #1;
            start3 = 1'b0;
            if (c + 1 == 3) check("l3 busy in wait", {31'h0, busy3}, 32'h1);
            if (mem_read3) begin
                reads++;
                if (reads == 2) second_read = c + 1;
            end
            if (done3) begin
                dones++;
                if (dones == 1) first_done = c + 1;
            end
        end
        check("l3 read count", reads, 2);
        check("l3 done count", dones, 2);
        check("l3 first done cycle", first_done, 5);
        check("l3 back-to-back read cycle", second_read, 6);
        check("l3 out", out3, 32'hFFFFFF80);

        // Reset during WAIT abandons the request
        start3 = 1'b1;
        @(posedge clock); #1;
        start3 = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        check("pre-rst busy", {31'h0, busy3}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("mid rst out", out3, 32'h0);
        check("mid rst mem_addr", mem_addr3, 32'h0);
        check("mid rst ctrl", {28'h0, mem_read3, busy3, done3, mis3}, 32'h0);
        @(posedge clock); @(posedge clock); #3;
        reset = 1'b1;
        reads = 0; dones = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); #1;
            if (mem_read3) reads++;
            if (done3) dones++;
        end
        check("post-rst reads", reads, 0);
        check("post-rst dones", dones, 0);
        check("post-rst out", out3, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
